serial_adder_4bit: RTL and testbench

SERIAL_ADDER_4BIT -- requirements
Module: serial_adder_4bit

---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/full_adder_1bit.sv | 17 +
 rtl/serial_adder_4bit.sv | 98 +++++++++
 tb/tb_serial_adder_4bit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Holds the FSM state encoding and the default operand width.
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full adder used as the per-cycle datapath of the serial adder.
// This is the addition counterpart of the 1-bit full subtractor.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic half_c;

    assign half_c = a ^ b;
    assign s      = half_c ^ cin;
    assign cout   = (a & b) | (half_c & cin);

endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per clock,
// LSB first, and publishes {cout,sum} with a one-cycle done pulse.
module serial_adder_4bit
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               bit_s_c;
    logic               bit_cout_c;
    logic [WIDTH-1:0]   res_next_c;

    full_adder_1bit u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (bit_s_c),
        .cout (bit_cout_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB result.
    assign res_next_c = WIDTH'({bit_s_c, res_sr} >> 1);

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next_c;
                    carry  <= bit_cout_c;
                    // Counter holds on the last bit so it never wraps inside RUN.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum   <= res_next_c;
                        cout  <= bit_cout_c;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Self-checking bench for serial_adder_4bit at WIDTH=4 and WIDTH=8.
// Expected results come from plain integer addition and the documented timing.
module tb_serial_adder_4bit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    int n_tests = 0;
    int n_fail  = 0;

    serial_adder_4bit #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    serial_adder_4bit #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_busy(input bit w8);
        return w8 ? 32'(busy8) : 32'(busy4);
    endfunction

    function automatic logic [31:0] f_done(input bit w8);
        return w8 ? 32'(done8) : 32'(done4);
    endfunction

    function automatic logic [31:0] f_sum(input bit w8);
        return w8 ? 32'(sum8) : 32'(sum4);
    endfunction

    function automatic logic [31:0] f_cout(input bit w8);
        return w8 ? 32'(cout8) : 32'(cout4);
    endfunction

    task automatic drive(input bit w8, input logic s, input logic [15:0] av,
                         input logic [15:0] bv, input logic cv);
        if (w8) begin
            start8 = s; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv;
        end else begin
            start4 = s; a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv;
        end
    endtask

    // One addition; with scramble, inputs and start toggle randomly while busy.
    task automatic run_op(input bit w8, input int unsigned av, input int unsigned bv,
                          input bit cv, input bit scramble);
        int unsigned w;
        int unsigned total;
        logic [31:0] prev_sum;
        int          lat;
        bit          seen;
        w        = w8 ? 8 : 4;
        total    = av + bv + 32'(cv);
        prev_sum = f_sum(w8);
        lat      = 0;
        seen     = 1'b0;
        @(negedge clk);
        drive(w8, 1'b1, 16'(av), 16'(bv), cv);
        @(negedge clk);
        drive(w8, 1'b0, 16'(av), 16'(bv), cv);
        check("busy_after_start", f_busy(w8), 32'd1);
        while (!seen && lat < 40) begin
            if (f_done(w8) == 32'd1) begin
                seen = 1'b1;
            end else begin
                check("sum_hold_during_run", f_sum(w8), prev_sum);
                if (scramble)
                    drive(w8, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                          1'($urandom_range(0, 1)));
                @(negedge clk);
                lat++;
            end
        end
        drive(w8, 1'b0, 16'(av), 16'(bv), cv);
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(lat), 32'(w));
            check("sum", f_sum(w8), total & ((32'd1 << w) - 32'd1));
            check("cout", f_cout(w8), total >> w);
            check("busy_in_done", f_busy(w8), 32'd1);
        end
        @(negedge clk);
        check("done_one_cycle", f_done(w8), 32'd0);
        check("busy_after_done", f_busy(w8), 32'd0);
    endtask

    initial begin
        int last;
        int pulses;
        int cyc;
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'd0, 16'd0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_sum4", 32'(sum4), 32'd0);
        check("rst_cout4", 32'(cout4), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_sum8", 32'(sum8), 32'd0);
        rst = 1'b0;

        // Directed cases.
        run_op(1'b0, 5, 3, 1'b0, 1'b0);
        run_op(1'b0, 15, 1, 1'b0, 1'b0);
        run_op(1'b0, 15, 15, 1'b1, 1'b0);

        // start held high: one result every WIDTH+2 cycles, operands changed while busy.
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd2; b4 = 4'd2; cin4 = 1'b0;
        last = -1; pulses = 0; cyc = 0;
        while (pulses < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done4) begin
                check("b2b_sum", 32'(sum4), 32'd4);
                check("b2b_cout", 32'(cout4), 32'd0);
                if (last >= 0) check("b2b_period", 32'(cyc - last), 32'd6);
                last = cyc;
                pulses++;
            end
            if (busy4) begin
                a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom_range(0, 1));
            end else begin
                a4 = 4'd2; b4 = 4'd2; cin4 = 1'b0;
            end
        end
        if (pulses < 3) check("b2b_timeout", 32'd0, 32'd1);
        start4 = 1'b0;
        @(negedge clk);

        // Reset two cycles into RUN abandons the operation.
        @(negedge clk);
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd6; cin4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy4), 32'd0);
        check("midrst_sum", 32'(sum4), 32'd0);
        check("midrst_cout", 32'(cout4), 32'd0);
        check("midrst_done", 32'(done4), 32'd0);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done4), 32'd0);
        end
        run_op(1'b0, 7, 6, 1'b1, 1'b0);

        // Exhaustive sweep at WIDTH=4 with start/operand noise while busy.
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_op(1'b0, 32'(ia), 32'(ib), 1'(ic), 1'b1);

        // WIDTH=8: corners then random vectors.
        run_op(1'b1, 255, 255, 1'b1, 1'b0);
        run_op(1'b1, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 128, 128, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++)
            run_op(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
                   1'($urandom_range(0, 1)), 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
